// File: rtl/victim_way_select_pkg.sv
// rtl/victim_way_select_pkg.sv - shared cache constants and victim FSM encoding
package victim_way_select_pkg;

  // Associativity shared by the tag array, controller and victim picker
  localparam int WAYS     = 4;
  localparam int WAY_BITS = 2;

  // Victim selection FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_HOLD   = 2'd2
  } victim_state_t;

endpackage

// File: rtl/victim_way_select_gray_counter.sv
// rtl/victim_way_select_gray_counter.sv - enable-gated gray-code counter
module gray_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             not_reset,
  input  logic             en,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] bin_q;

  // Binary count advances only when enabled; gray value is derived from it
  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      bin_q <= '0;
    end else if (en) begin
      bin_q <= bin_q + WIDTH'(1);
    end
  end

  assign value = bin_q ^ (bin_q >> 1);

endmodule

// File: rtl/victim_way_select.sv
// rtl/victim_way_select.sv - replacement way picker for set-associative misses
module victim_way_select
  import victim_way_select_pkg::*;
#(
  parameter int WAYS      = victim_way_select_pkg::WAYS,
  parameter int WAY_BITS  = victim_way_select_pkg::WAY_BITS,
  parameter int CNT_WIDTH = 3
) (
  input  logic                clk,
  input  logic                not_reset,
  input  logic                req,
  input  logic [WAYS-1:0]     valid_bits,
  input  logic [WAYS-1:0]     dirty_bits,
  input  logic                fill_done,
  output logic                busy,
  output logic                victim_ready,
  output logic [WAY_BITS-1:0] victim_way,
  output logic                victim_dirty
);

  victim_state_t       state_q;
  victim_state_t       state_d;
  logic [WAYS-1:0]     valid_q;
  logic [WAYS-1:0]     dirty_q;
  logic [CNT_WIDTH-1:0] gray_val;
  logic                cnt_en;
  logic [WAY_BITS-1:0] sel_way;
  logic                sel_dirty;
  logic                unused_gray_high;

  // Lowest-index way whose valid flag is clear (0 when the set is full)
  function automatic logic [WAY_BITS-1:0] lowest_invalid(input logic [WAYS-1:0] v);
    logic [WAY_BITS-1:0] idx;
    idx = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!v[i]) idx = i[WAY_BITS-1:0];
    end
    return idx;
  endfunction

  gray_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_gray_counter (
    .clk      (clk),
    .not_reset(not_reset),
    .en       (cnt_en),
    .value    (gray_val)
  );

  // Only the low bits of the counter index a way; the rest just lengthen the period
  assign unused_gray_high = ^gray_val;

  // Next-state and victim choice; the counter is consumed only on a full set
  always_comb begin
    state_d   = state_q;
    cnt_en    = 1'b0;
    sel_way   = lowest_invalid(valid_q);
    sel_dirty = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        state_d = ST_HOLD;
        if (&valid_q) begin
          sel_way   = gray_val[WAY_BITS-1:0];
          sel_dirty = dirty_q[sel_way];
          cnt_en    = 1'b1;
        end
      end
      ST_HOLD: begin
        if (fill_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, captured set flags and the registered victim decision
  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      state_q      <= ST_IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      victim_way   <= '0;
      victim_dirty <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && req) begin
        valid_q <= valid_bits;
        dirty_q <= dirty_bits;
      end
      if (state_q == ST_SELECT) begin
        victim_way   <= sel_way;
        victim_dirty <= sel_dirty;
      end
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign victim_ready = (state_q == ST_HOLD);

endmodule

// File: tb/tb_victim_way_select.sv
// tb/tb_victim_way_select.sv - randomized self-checking bench for victim_way_select
module tb_victim_way_select;

  logic       clk;
  logic       not_reset;
  logic       req;
  logic [3:0] valid_bits;
  logic [3:0] dirty_bits;
  logic       fill_done;
  logic       busy;
  logic       victim_ready;
  logic [1:0] victim_way;
  logic       victim_dirty;

  int total;
  int bad;
  int full_cnt;
  int gray_seq [8];

  victim_way_select #(
    .WAYS     (4),
    .WAY_BITS (2),
    .CNT_WIDTH(3)
  ) dut (
    .clk         (clk),
    .not_reset   (not_reset),
    .req         (req),
    .valid_bits  (valid_bits),
    .dirty_bits  (dirty_bits),
    .fill_done   (fill_done),
    .busy        (busy),
    .victim_ready(victim_ready),
    .victim_way  (victim_way),
    .victim_dirty(victim_dirty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference choice: first invalid way, else next entry of the gray sequence
  task automatic model_pick(input logic [3:0] v, input logic [3:0] d,
                            output int exp_way, output int exp_dirty);
    int first;
    first = -1;
    for (int i = 0; i < 4; i++) begin
      if (v[i] == 1'b0 && first < 0) first = i;
    end
    if (first >= 0) begin
      exp_way   = first;
      exp_dirty = 0;
    end else begin
      exp_way   = gray_seq[full_cnt % 8] % 4;
      exp_dirty = d[exp_way];
      full_cnt++;
    end
  endtask

  // Present a miss, check latency and the decision, then optionally poke req in HOLD
  task automatic start_miss(input logic [3:0] v, input logic [3:0] d, input int pokes);
    int ew;
    int ed;
    @(negedge clk);
    req = 1'b1; valid_bits = v; dirty_bits = d;
    @(negedge clk);
    req = 1'b0; valid_bits = 4'($urandom); dirty_bits = 4'($urandom);
    check("select_busy", 32'(busy), 32'd1);
    check("select_not_ready", 32'(victim_ready), 32'd0);
    model_pick(v, d, ew, ed);
    @(negedge clk);
    check("hold_ready", 32'(victim_ready), 32'd1);
    check("hold_way", 32'(victim_way), 32'(ew));
    check("hold_dirty", 32'(victim_dirty), 32'(ed));
    for (int p = 0; p < pokes; p++) begin
      req = 1'b1; valid_bits = ~v; dirty_bits = ~d;
      @(negedge clk);
      check("poke_ready", 32'(victim_ready), 32'd1);
      check("poke_way", 32'(victim_way), 32'(ew));
      check("poke_dirty", 32'(victim_dirty), 32'(ed));
    end
    req = 1'b0;
  endtask

  // Close the refill, optionally with a simultaneous req that must be dropped
  task automatic finish_miss(input bit with_req);
    fill_done = 1'b1; req = with_req; valid_bits = 4'($urandom);
    @(negedge clk);
    fill_done = 1'b0; req = 1'b0;
    check("done_busy", 32'(busy), 32'd0);
    check("done_ready", 32'(victim_ready), 32'd0);
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    total = 0; bad = 0; full_cnt = 0;
    gray_seq = '{0, 1, 3, 2, 6, 7, 5, 4};
    not_reset = 1'b0; req = 1'b0; fill_done = 1'b0;
    valid_bits = '0; dirty_bits = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(victim_ready), 32'd0);
    check("rst_way", 32'(victim_way), 32'd0);
    check("rst_dirty", 32'(victim_dirty), 32'd0);
    @(negedge clk);
    not_reset = 1'b1;

    // Invalid-way fill leaves the counter alone
    start_miss(4'b1011, 4'b1111, 0);
    finish_miss(1'b0);
    // First full miss picks way 0 and reports its dirty flag
    start_miss(4'b1111, 4'b0001, 0);
    finish_miss(1'b0);
    for (int k = 0; k < 4; k++) begin
      start_miss(4'b1111, 4'b0000, 2);
      finish_miss(1'b0);
    end

    // fill_done while idle is ignored
    @(negedge clk);
    fill_done = 1'b1;
    @(negedge clk);
    fill_done = 1'b0;
    check("idle_fill_busy", 32'(busy), 32'd0);
    check("idle_fill_ready", 32'(victim_ready), 32'd0);

    // req together with fill_done in HOLD is dropped
    start_miss(4'b0111, 4'b1000, 1);
    finish_miss(1'b1);

    // Asynchronous reset in HOLD after three full misses restarts the counter
    @(negedge clk);
    not_reset = 1'b0;
    #1;
    not_reset = 1'b1;
    full_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      start_miss(4'b1111, 4'b1010, 0);
      finish_miss(1'b0);
    end
    start_miss(4'b1111, 4'b1111, 0);
    #2;
    not_reset = 1'b0;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_ready", 32'(victim_ready), 32'd0);
    check("async_way", 32'(victim_way), 32'd0);
    check("async_dirty", 32'(victim_dirty), 32'd0);
    @(negedge clk);
    not_reset = 1'b1;
    full_cnt = 0;
    start_miss(4'b1111, 4'b0000, 0);
    finish_miss(1'b0);

    // Randomized misses against the reference model
    for (int n = 0; n < 150; n++) begin
      logic [3:0] v;
      logic [3:0] d;
      v = ($urandom_range(0, 1) == 1) ? 4'b1111 : 4'($urandom);
      d = 4'($urandom);
      start_miss(v, d, int'($urandom_range(0, 2)));
      finish_miss(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        fill_done = 1'b1;
        @(negedge clk);
        fill_done = 1'b0;
        check("rand_idle_fill", 32'(busy), 32'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
